// File: rtl/dla_demux_sel_scheduler.sv
// Per-layer select sequencer feeding a 1:2 stream demux config port.
// Optional replay of the loaded program: DLA_DEMUX_SCHED_REPEAT_EN.
module dla_demux_sel_scheduler #(
    parameter int CONFIG_WIDTH    = 32,
    parameter int MAX_LAYERS      = 16,
    parameter int DEMUX_CFG_WORDS = 1
) (
    input  logic                              clk_dla,
    input  logic                              i_resetn,
    input  logic [CONFIG_WIDTH-1:0]           i_config_data,
    input  logic                              i_config_valid,
    output logic                              o_config_ready,
    output logic [CONFIG_WIDTH-1:0]           o_demux_config_data,
    output logic                              o_demux_config_valid,
    input  logic                              i_demux_config_ready,
`ifdef DLA_DEMUX_SCHED_REPEAT_EN
    input  logic                              i_repeat,
`endif
    input  logic                              i_transmitter_done,
    output logic [$clog2(MAX_LAYERS+1)-1:0]   o_layer_idx,
    output logic                              o_busy,
    output logic                              o_done,
    output logic                              o_cfg_error,
    output logic                              o_protocol_error
);

    localparam int IW    = $clog2(MAX_LAYERS + 1);
    localparam int DEPTH = 1 << IW;
    localparam int WW    = (DEMUX_CFG_WORDS > 1) ? $clog2(DEMUX_CFG_WORDS) : 1;

    localparam logic [WW-1:0] LAST_W = WW'(DEMUX_CFG_WORDS - 1);
    localparam logic [IW-1:0] MAX_L  = IW'(MAX_LAYERS);
    localparam logic [15:0]   MAX16  = 16'(MAX_LAYERS);

    typedef enum logic [1:0] {
        LOAD_COUNT,
        LOAD_SEL,
        ISSUE,
        WAIT_DONE
    } state_t;

    state_t                  state;
    logic [15:0]             total;
    logic [15:0]             cnt;
    logic [IW-1:0]           eff;
    logic [IW-1:0]           layer;
    logic [WW-1:0]           wcnt;
    logic [DEPTH-1:0]        store;
    logic [CONFIG_WIDTH-1:0] data;
    logic                    valid;
    logic                    done;
    logic                    cfg_err;
    logic                    proto_err;

    logic [15:0] count_in;
    logic        first_sel;
    logic        last_layer;
    logic        unused_hi;

    assign count_in   = i_config_data[15:0];
    assign unused_hi  = ^i_config_data[CONFIG_WIDTH-1:16];
    // Program of one layer: store[0] is written on the same edge we issue it.
    assign first_sel  = (cnt == 16'd0) ? i_config_data[0] : store[0];
    assign last_layer = (layer == eff - IW'(1));

    // Select store needs no reset; contents are only read after a full load.
    always_ff @(posedge clk_dla) begin
        if (state == LOAD_SEL && i_config_valid && cnt < 16'(eff))
            store[cnt[IW-1:0]] <= i_config_data[0];
    end

    always_ff @(posedge clk_dla) begin
        if (!i_resetn) begin
            state     <= LOAD_COUNT;
            total     <= '0;
            cnt       <= '0;
            eff       <= '0;
            layer     <= '0;
            wcnt      <= '0;
            data      <= '0;
            valid     <= 1'b0;
            done      <= 1'b0;
            cfg_err   <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            done <= 1'b0;
            if (i_transmitter_done && state != WAIT_DONE)
                proto_err <= 1'b1;
            unique case (state)
                LOAD_COUNT: begin
                    if (i_config_valid) begin
                        total <= count_in;
                        cnt   <= '0;
                        if (count_in == 16'd0) begin
                            cfg_err <= 1'b1;
                            done    <= 1'b1;
                        end else begin
                            if (count_in > MAX16) begin
                                cfg_err <= 1'b1;
                                eff     <= MAX_L;
                            end else begin
                                eff <= count_in[IW-1:0];
                            end
                            state <= LOAD_SEL;
                        end
                    end
                end
                LOAD_SEL: begin
                    if (i_config_valid) begin
                        cnt <= cnt + 16'd1;
                        if (cnt == total - 16'd1) begin
                            state <= ISSUE;
                            layer <= '0;
                            wcnt  <= '0;
                            valid <= 1'b1;
                            data  <= {{(CONFIG_WIDTH-1){1'b0}}, first_sel};
                        end
                    end
                end
                ISSUE: begin
                    if (i_demux_config_ready) begin
                        data <= '0;
                        if (wcnt == LAST_W) begin
                            valid <= 1'b0;
                            state <= WAIT_DONE;
                        end else begin
                            wcnt <= wcnt + WW'(1);
                        end
                    end
                end
                WAIT_DONE: begin
                    if (i_transmitter_done) begin
                        if (last_layer) begin
                            done  <= 1'b1;
                            layer <= '0;
`ifdef DLA_DEMUX_SCHED_REPEAT_EN
                            if (i_repeat) begin
                                state <= ISSUE;
                                wcnt  <= '0;
                                valid <= 1'b1;
                                data  <= {{(CONFIG_WIDTH-1){1'b0}}, store[0]};
                            end else begin
                                state <= LOAD_COUNT;
                            end
`else
                            state <= LOAD_COUNT;
`endif
                        end else begin
                            layer <= layer + IW'(1);
                            wcnt  <= '0;
                            valid <= 1'b1;
                            data  <= {{(CONFIG_WIDTH-1){1'b0}},
                                      store[layer + IW'(1)]};
                            state <= ISSUE;
                        end
                    end
                end
            endcase
        end
    end

    assign o_config_ready       = (state == LOAD_COUNT) || (state == LOAD_SEL);
    assign o_demux_config_data  = data;
    assign o_demux_config_valid = valid;
    assign o_layer_idx          = layer;
    assign o_busy               = (state != LOAD_COUNT);
    assign o_done               = done;
    assign o_cfg_error          = cfg_err;
    assign o_protocol_error     = proto_err;

endmodule

// File: tb/tb_dla_demux_sel_scheduler.sv
// Directed bench for dla_demux_sel_scheduler (1-word and 2-word configs).
module tb_dla_demux_sel_scheduler;

    logic        clk = 1'b0;
    logic        resetn;

    logic [31:0] cd0, cd1;
    logic        cv0, cv1, dr0, dr1, td0, td1;
    logic        rdy0, rdy1, val0, val1, busy0, busy1, done0, done1;
    logic        cerr0, cerr1, perr0, perr1;
    logic [31:0] dd0, dd1;
    logic [4:0]  li0, li1;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    dla_demux_sel_scheduler #(.DEMUX_CFG_WORDS(1)) u0 (
        .clk_dla(clk), .i_resetn(resetn),
        .i_config_data(cd0), .i_config_valid(cv0), .o_config_ready(rdy0),
        .o_demux_config_data(dd0), .o_demux_config_valid(val0),
        .i_demux_config_ready(dr0), .i_transmitter_done(td0),
        .o_layer_idx(li0), .o_busy(busy0), .o_done(done0),
        .o_cfg_error(cerr0), .o_protocol_error(perr0)
    );

    dla_demux_sel_scheduler #(.DEMUX_CFG_WORDS(2)) u1 (
        .clk_dla(clk), .i_resetn(resetn),
        .i_config_data(cd1), .i_config_valid(cv1), .o_config_ready(rdy1),
        .o_demux_config_data(dd1), .o_demux_config_valid(val1),
        .i_demux_config_ready(dr1), .i_transmitter_done(td1),
        .o_layer_idx(li1), .o_busy(busy1), .o_done(done1),
        .o_cfg_error(cerr1), .o_protocol_error(perr1)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send0(input logic [31:0] w);
        cd0 = w; cv0 = 1'b1;
        tick();
        cv0 = 1'b0;
    endtask

    task automatic send1(input logic [31:0] w);
        cd1 = w; cv1 = 1'b1;
        tick();
        cv1 = 1'b0;
    endtask

    task automatic pulse0();
        td0 = 1'b1;
        tick();
        td0 = 1'b0;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
    endtask

    initial begin
        resetn = 1'b0;
        cd0 = '0; cv0 = 0; dr0 = 1; td0 = 0;
        cd1 = '0; cv1 = 0; dr1 = 0; td1 = 0;
        tick();
        tick();
        chk("rst_ready", rdy0, 1);
        chk("rst_valid", val0, 0);
        chk("rst_busy", busy0, 0);
        chk("rst_done", done0, 0);
        chk("rst_layer", li0, 0);
        chk("rst_cerr", cerr0, 0);
        chk("rst_perr", perr0, 0);
        chk("rst_data", dd0, 0);
        resetn = 1'b1;

        // L=3, selects 1,0,1
        send0(3);
        chk("t1_busy_sel", busy0, 1);
        send0(1);
        send0(0);
        send0(1);
        chk("t1_v0", val0, 1);
        chk("t1_d0", dd0, 1);
        chk("t1_l0", li0, 0);
        chk("t1_rdy_issue", rdy0, 0);
        tick();
        chk("t1_v0_drop", val0, 0);
        tick();
        tick();
        chk("t1_no_early", val0, 0);
        pulse0();
        chk("t1_v1", val0, 1);
        chk("t1_d1", dd0, 0);
        chk("t1_l1", li0, 1);
        tick();
        chk("t1_v1_drop", val0, 0);
        pulse0();
        chk("t1_v2", val0, 1);
        chk("t1_d2", dd0, 1);
        chk("t1_l2", li0, 2);
        tick();
        chk("t1_done_early", done0, 0);
        pulse0();
        chk("t1_done", done0, 1);
        chk("t1_busy_end", busy0, 0);
        chk("t1_layer_end", li0, 0);
        tick();
        chk("t1_done_one", done0, 0);
        chk("t1_cerr", cerr0, 0);

        // L=0
        send0(0);
        chk("t3_cerr", cerr0, 1);
        chk("t3_done", done0, 1);
        chk("t3_ready", rdy0, 1);
        chk("t3_valid", val0, 0);
        chk("t3_busy", busy0, 0);
        tick();
        chk("t3_done_one", done0, 0);
        do_reset();
        chk("t3_cerr_clr", cerr0, 0);

        // L=18, all selects 1: 18 words taken, 16 layers issued
        send0(18);
        chk("t4_cerr", cerr0, 1);
        for (int i = 0; i < 17; i++) begin
            chk("t4_ready", rdy0, 1);
            send0(1);
        end
        chk("t4_ready17", rdy0, 1);
        chk("t4_no_issue", val0, 0);
        send0(1);
        for (int i = 0; i < 16; i++) begin
            chk("t4_valid", val0, 1);
            chk("t4_data", dd0, 1);
            chk("t4_layer", li0, i);
            tick();
            pulse0();
        end
        chk("t4_done", done0, 1);
        chk("t4_no17", val0, 0);
        chk("t4_busy", busy0, 0);
        do_reset();

        // done pulses outside WAIT_DONE
        send0(2);
        cd0 = 0; cv0 = 1; td0 = 1;
        tick();
        cv0 = 0; td0 = 0;
        chk("t5_perr_sel", perr0, 1);
        chk("t5_busy", busy0, 1);
        send0(1);
        chk("t5_v0", val0, 1);
        chk("t5_d0", dd0, 0);
        dr0 = 0; td0 = 1;
        tick();
        td0 = 0;
        chk("t5_hold_v", val0, 1);
        chk("t5_hold_l", li0, 0);
        dr0 = 1;
        tick();
        chk("t5_v0_drop", val0, 0);
        pulse0();
        chk("t5_v1", val0, 1);
        chk("t5_d1", dd0, 1);
        chk("t5_l1", li0, 1);
        tick();
        pulse0();
        chk("t5_done", done0, 1);
        chk("t5_perr_sticky", perr0, 1);

        // reset while waiting on layer 1 of 3
        send0(3);
        send0(1);
        send0(1);
        send0(0);
        tick();
        pulse0();
        tick();
        chk("t6_pre_layer", li0, 1);
        chk("t6_pre_valid", val0, 0);
        do_reset();
        chk("t6_state", rdy0, 1);
        chk("t6_valid", val0, 0);
        chk("t6_busy", busy0, 0);
        chk("t6_layer", li0, 0);
        chk("t6_perr", perr0, 0);
        chk("t6_cerr", cerr0, 0);
        send0(1);
        send0(1);
        chk("t6_v", val0, 1);
        chk("t6_d", dd0, 1);
        tick();
        pulse0();
        chk("t6_done", done0, 1);
        chk("t6_busy_end", busy0, 0);

        // two config words, ready low 4 cycles on word 0
        send1(1);
        send1(1);
        for (int i = 0; i < 4; i++) begin
            chk("t2_hold_v", val1, 1);
            chk("t2_hold_d", dd1, 1);
            tick();
        end
        chk("t2_hold_v4", val1, 1);
        dr1 = 1;
        tick();
        chk("t2_w1_v", val1, 1);
        chk("t2_w1_d", dd1, 0);
        tick();
        chk("t2_drop", val1, 0);
        chk("t2_busy", busy1, 1);
        td1 = 1;
        tick();
        td1 = 0;
        chk("t2_done", done1, 1);
        chk("t2_perr", perr1, 0);
        chk("t2_busy_end", busy1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dla_demux_sel_scheduler.md
Name: dla_demux_sel_scheduler

Overview:
- Per-layer sequencer for a 1:2 stream demux.
- Loads a short program from the config stream: a layer count, then one select value per layer.
- For each layer, emits the demux's select configuration, then waits for the upstream transmitter-done pulse before moving to the next layer.
- Sits between the DMA/config network and the demux config port.

Parameters:
- CONFIG_WIDTH, 32: width of the config input and output words.
- MAX_LAYERS, 16: depth of the select store, ≥1. Index width is clog2(MAX_LAYERS+1).
- DEMUX_CFG_WORDS, 1: number of CONFIG_WIDTH words per demux configuration, ≥1.

Ports:
- clk_dla  in  1  clock.
- i_resetn  in  1  reset: synchronous, active-low.
- i_config_data  in  CONFIG_WIDTH  program word.
- i_config_valid  in  1  program word valid.
- o_config_ready  out  1  program word accepted when valid&ready.
- o_demux_config_data  out  CONFIG_WIDTH  word to demux.
- o_demux_config_valid  out  1  valid to demux.
- i_demux_config_ready  in  1  demux config ready.
- i_transmitter_done  in  1  single-cycle end-of-layer pulse (also drives the demux).
- o_layer_idx  out  clog2(MAX_LAYERS+1)  index of the current layer.
- o_busy  out  1  high from the first select load until the final done.
- o_done  out  1  one-cycle pulse when the program completes.
- o_cfg_error  out  1  sticky bad-count flag.
- o_protocol_error  out  1  sticky unexpected-done flag.

Behaviour:
- Reset (i_resetn=0 at a clock edge):
  - state=LOAD_COUNT.
  - All outputs 0, except o_config_ready=1.
  - Select store contents are don't-care.
  - A reset mid-program abandons the program immediately.
  - Sticky errors clear only on reset.
- State LOAD_COUNT:
  - o_config_ready=1.
  - On accept, L = i_config_data[15:0].
  - L=0: set o_cfg_error, pulse o_done next cycle, stay in LOAD_COUNT.
  - L>MAX_LAYERS: set o_cfg_error, effective count E=MAX_LAYERS, but all L select words are still consumed.
  - Otherwise E=L.
  - For L≥1, go to LOAD_SEL with load counter=0.
- State LOAD_SEL:
  - o_config_ready=1.
  - Each accepted word stores bit0 at store[cnt] when cnt<E; words with cnt≥E are discarded.
  - cnt increments by 1 per accept.
  - On accepting word L-1, go to ISSUE with layer=0 and word counter=0.
- State ISSUE:
  - o_config_ready=0.
  - o_demux_config_valid=1 (registered).
  - Word 0 = {zeros, store[layer]}; words 1..DEMUX_CFG_WORDS-1 are all-zero.
  - Data holds stable while valid=1 and ready=0.
  - Word counter advances on valid&ready.
  - On the last word handshake, valid drops next cycle and the state goes to WAIT_DONE.
  - First valid appears 1 cycle after the last select accept.
- State WAIT_DONE:
  - On i_transmitter_done: if layer==E-1, pulse o_done, clear o_busy, go to LOAD_COUNT.
  - Otherwise layer+1 and go to ISSUE; next config valid appears 1 cycle later.
- i_transmitter_done outside WAIT_DONE: ignored, sets o_protocol_error, no state change.
- o_layer_idx tracks layer during ISSUE/WAIT_DONE; 0 otherwise.
- o_busy=1 in LOAD_SEL, ISSUE and WAIT_DONE.
- Layer and word counters never wrap; they are bounded by E and DEMUX_CFG_WORDS.

Optional Feature:
- Macro: DLA_DEMUX_SCHED_REPEAT_EN.
- Defined:
  - Adds input i_repeat (1).
  - If i_repeat=1 when the final done arrives: o_done still pulses, the store is retained, the state goes to ISSUE with layer=0, and the select sequence replays without reloading.
  - If i_repeat=0, behaviour is as below.
- Undefined: no i_repeat port; the final done always returns to LOAD_COUNT.

Test Plan:
- L=3, selects 1,0,1, DEMUX_CFG_WORDS=1, demux ready=1:
  - Config data words are 1, 0, 1.
  - Each word is issued only after the preceding done pulse.
  - o_layer_idx goes 0,1,2.
  - o_done pulses 1 cycle after the 3rd done.
  - o_busy returns to 0.
- DEMUX_CFG_WORDS=2, ready low for 4 cycles during word 0:
  - data=0x1 is held stable with valid=1 throughout.
  - Word 1=0x0 is then emitted.
  - WAIT_DONE is entered only after the word-1 handshake.
- L=0:
  - o_cfg_error=1 and o_done pulses.
  - No demux config is issued and o_config_ready stays 1.
- L=MAX_LAYERS+2 (18), all selects=1:
  - All 18 words are accepted.
  - Exactly 16 configs are issued.
  - o_cfg_error=1.
- i_transmitter_done pulsed during LOAD_SEL and during ISSUE:
  - o_protocol_error=1.
  - Load and issue progress are unaffected.
- i_resetn=0 for 1 cycle while in WAIT_DONE on layer 1 of 3:
  - Next cycle: state LOAD_COUNT, o_demux_config_valid=0, o_busy=0, o_layer_idx=0, errors cleared.
  - A fresh program with L=1 then completes normally.
